// File: rtl/s_mem_arb_pkg.sv
// s_mem_arb_pkg: shared state type and default sizes for the s_memory arbiter
package s_mem_arb_pkg;
    typedef enum logic {IDLE, GRANT} arb_state_t;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;
    localparam int S_MEM_DEPTH = 256;
endpackage

// File: rtl/s_mem_arbiter_rr.sv
// rr_picker: combinational round-robin pick of one request, scanning upward from ptr with wrap
module rr_picker #(
    parameter  int N  = 3,
    localparam int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic          valid
);
    logic [PW-1:0] idx;
    // walk the ring backwards so the request closest to ptr is written last and wins
    always_comb begin
        win = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = PW'((int'(ptr) + i) % N);
            if (req[idx]) begin
                win      = '0;
                win[idx] = 1'b1;
            end
        end
    end
    assign valid = |req;
endmodule

// File: rtl/s_mem_arbiter.sv
// s_mem_arbiter: round-robin, hold-while-requesting arbiter sharing one s_memory port; S_MEM_ARBITER_TIMEOUT_EN adds grant-hold preemption
module s_mem_arbiter
    import s_mem_arb_pkg::*;
#(
    parameter  int N_REQ    = 3,
    parameter  int ADDR_W   = DEF_ADDR_W,
    parameter  int DATA_W   = DEF_DATA_W,
    parameter  int MAX_HOLD = 64,
    localparam int PW       = $clog2(N_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic [N_REQ*ADDR_W-1:0]    req_addr,
    input  logic [N_REQ*DATA_W-1:0]    req_wdata,
    input  logic [N_REQ-1:0]           req_wren,
    output logic [N_REQ-1:0]           gnt,
    output logic [DATA_W-1:0]          rd_data,
    output logic [N_REQ-1:0]           rd_valid,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [DATA_W-1:0]          mem_data,
    output logic                       mem_wren,
    input  logic [DATA_W-1:0]          mem_q
);
    arb_state_t       state, state_n;
    logic [N_REQ-1:0] gnt_n, pick;
    logic [PW-1:0]    ptr, ptr_n, hold, nxt, pick_ptr;
    logic             pick_ok, revoke, unused_cfg;

    // holder index, its ring successor, and the RAM mux driven only during an access cycle
    always_comb begin
        hold        = '0;
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) hold = PW'(i);
            if (gnt[i] && req[i]) begin
                mem_address = req_addr[i*ADDR_W +: ADDR_W];
                mem_data    = req_wdata[i*DATA_W +: DATA_W];
                mem_wren    = req_wren[i] & rst;
            end
        end
        nxt = (hold == PW'(N_REQ - 1)) ? '0 : hold + 1'b1;
    end

    assign pick_ptr = (state == GRANT) ? nxt : ptr;
    assign rd_data  = mem_q;

    rr_picker #(.N(N_REQ)) u_pick (
        .req   (req & ~gnt),
        .ptr   (pick_ptr),
        .win   (pick),
        .valid (pick_ok)
    );

    // grant from idle, or hand over to the next round-robin winner when the holder releases or is revoked
    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        ptr_n   = ptr;
        if (state == IDLE) begin
            gnt_n   = pick;
            state_n = pick_ok ? GRANT : IDLE;
        end else if (!req[hold] || revoke) begin
            gnt_n   = pick;
            ptr_n   = nxt;
            state_n = pick_ok ? GRANT : IDLE;
        end
    end

    // arbitration state and the read strobe one cycle behind each read access
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ptr      <= '0;
            rd_valid <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            ptr      <= ptr_n;
            rd_valid <= gnt & req & ~req_wren;
        end
    end

`ifdef S_MEM_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(MAX_HOLD);
    logic [CW-1:0] hold_cnt;
    // tenure length, saturating at the limit and restarting whenever the grant changes
    always_ff @(posedge clk) begin
        if (!rst) hold_cnt <= '0;
        else hold_cnt <= (gnt_n != gnt) ? '0 :
                         (state == GRANT && hold_cnt != CW'(MAX_HOLD - 1)) ? hold_cnt + 1'b1 : hold_cnt;
    end
    assign revoke     = (state == GRANT) && (hold_cnt == CW'(MAX_HOLD - 1)) && !lock[hold] && pick_ok;
    assign unused_cfg = (S_MEM_DEPTH == 0);
`else
    assign revoke     = 1'b0;
    assign unused_cfg = ^lock ^ (MAX_HOLD == 0) ^ (S_MEM_DEPTH == 0);
`endif
endmodule

// File: tb/tb_s_mem_arbiter.sv
// tb_s_mem_arbiter: vector table, corner sequences and random traffic against a behavioural arbiter/RAM model
module tb_s_mem_arbiter;
    localparam int N = 3, AW = 8, DW = 8, MH = 8;

    logic clk = 1'b0;
    logic rst, mem_wren, ram_init;
    logic [N-1:0] req, lock, req_wren, gnt, rd_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0] rd_data, mem_data, mem_q;
    logic [AW-1:0] mem_address;
    logic [7:0] ram [256];

    typedef struct {
        logic       rst;
        logic [2:0] req, wren;
        logic [7:0] addr, wdata;
        logic [2:0] eg, ev;
        logic       ew;
        logic [7:0] ea, ed;
    } vec_t;
    vec_t tv[$];

    int m_own = -1, m_ptr = 0, m_rv = -1, m_cnt = 0;
    logic [7:0] m_rd;
    logic [7:0] m_mem [256];
    int vectors = 0, miscompares = 0;

    always #5 clk = ~clk;

    s_mem_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst), .req(req), .lock(lock), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wren(req_wren), .gnt(gnt), .rd_data(rd_data),
        .rd_valid(rd_valid), .mem_address(mem_address), .mem_data(mem_data),
        .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i);
        end else begin
            if (mem_wren) ram[mem_address] <= mem_data;
            mem_q <= ram[mem_address];
        end
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bit_at(logic [N-1:0] v, int j);
        logic [N-1:0] t;
        t = v >> j;
        return t[0];
    endfunction

    function automatic logic [7:0] addr_of(int k);
        logic [N*AW-1:0] t;
        t = req_addr >> (k * AW);
        return t[7:0];
    endfunction

    function automatic logic [7:0] data_of(int k);
        logic [N*DW-1:0] t;
        t = req_wdata >> (k * DW);
        return t[7:0];
    endfunction

    function automatic int first_from(logic [N-1:0] v, int s);
        for (int i = 0; i < N; i++) if (bit_at(v, (s + i) % N)) return (s + i) % N;
        return -1;
    endfunction

    function automatic bit timed_out(logic [N-1:0] others);
`ifdef S_MEM_ARBITER_TIMEOUT_EN
        return m_cnt == MH - 1 && !bit_at(lock, m_own) && others != 0;
`else
        return others != others;
`endif
    endfunction

    task automatic check_model();
        logic acc;
        acc = m_own >= 0 && bit_at(req, m_own);
        chk("gnt", gnt, m_own >= 0 ? 32'(1) << m_own : 32'(0));
        chk("rd_valid", rd_valid, m_rv >= 0 ? 32'(1) << m_rv : 32'(0));
        chk("mem_wren", mem_wren, 32'(acc && rst && bit_at(req_wren, m_own)));
        chk("mem_address", mem_address, acc ? 32'(addr_of(m_own)) : 32'(0));
        chk("mem_data", mem_data, acc ? 32'(data_of(m_own)) : 32'(0));
        if (m_rv >= 0) chk("rd_data", rd_data, 32'(m_rd));
    endtask

    task automatic model_edge();
        logic [N-1:0] others;
        if (!rst) begin
            m_own = -1; m_ptr = 0; m_rv = -1; m_cnt = 0;
            return;
        end
        m_rv = -1;
        if (m_own >= 0 && bit_at(req, m_own)) begin
            if (bit_at(req_wren, m_own)) m_mem[addr_of(m_own)] = data_of(m_own);
            else begin
                m_rv = m_own;
                m_rd = m_mem[addr_of(m_own)];
            end
        end
        if (m_own < 0) begin
            m_own = first_from(req, m_ptr);
            m_cnt = 0;
            return;
        end
        others = req & ~(N'(1) << m_own);
        if (!bit_at(req, m_own) || timed_out(others)) begin
            m_ptr = (m_own + 1) % N;
            m_own = first_from(others, m_ptr);
            m_cnt = 0;
        end else if (m_cnt < MH - 1) m_cnt++;
    endtask

    task automatic fin();
        check_model();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req = '0; lock = '0; req_wren = '0;
        @(negedge clk);
        fin();
        rst = 1'b1;
    endtask

    task automatic row(logic r, logic [2:0] rq, logic [2:0] wr, logic [7:0] a, logic [7:0] d,
                       logic [2:0] eg, logic [2:0] ev, logic ew, logic [7:0] ea, logic [7:0] ed);
        vec_t t;
        t.rst = r; t.req = rq; t.wren = wr; t.addr = a; t.wdata = d;
        t.eg = eg; t.ev = ev; t.ew = ew; t.ea = ea; t.ed = ed;
        tv.push_back(t);
    endtask

    task automatic rand_data();
        req_addr  = (N*AW)'($urandom);
        req_wdata = (N*DW)'($urandom);
        if ($urandom_range(0, 1) == 0) req_addr = req_addr & {N{8'h0f}};
    endtask

    initial begin
        logic [2:0] exp;
        logic [N-1:0] r;
        rst = 1'b0; req = '0; lock = '0; req_wren = '0; req_addr = '0; req_wdata = '0; ram_init = 1'b1;
        for (int i = 0; i < 256; i++) m_mem[i] = 8'(i);
        @(posedge clk);
        #1;
        ram_init = 1'b0;

        // single requester write/read, reset during a granted write, then a swap tenure with req[1] pending
        row(0, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3'b000, 0, 8'h00, 8'h00);
        row(1, 3'b001, 3'b001, 8'h10, 8'hA5, 3'b000, 3'b000, 0, 8'h00, 8'h00);
        row(1, 3'b001, 3'b001, 8'h10, 8'hA5, 3'b001, 3'b000, 1, 8'h10, 8'h00);
        row(1, 3'b001, 3'b000, 8'h10, 8'h00, 3'b001, 3'b000, 0, 8'h10, 8'h00);
        row(1, 3'b001, 3'b000, 8'h20, 8'h00, 3'b001, 3'b001, 0, 8'h20, 8'hA5);
        row(1, 3'b000, 3'b000, 8'h20, 8'h00, 3'b001, 3'b001, 0, 8'h00, 8'h20);
        row(1, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3'b000, 0, 8'h00, 8'h00);
        row(1, 3'b011, 3'b011, 8'h30, 8'h5A, 3'b000, 3'b000, 0, 8'h00, 8'h00);
        row(1, 3'b011, 3'b011, 8'h30, 8'h5A, 3'b010, 3'b000, 1, 8'h30, 8'h00);
        row(0, 3'b011, 3'b011, 8'h30, 8'h5A, 3'b010, 3'b000, 0, 8'h30, 8'h00);
        row(1, 3'b011, 3'b000, 8'h30, 8'h00, 3'b000, 3'b000, 0, 8'h00, 8'h00);
        row(1, 3'b011, 3'b000, 8'h30, 8'h00, 3'b001, 3'b000, 0, 8'h30, 8'h00);
        row(1, 3'b000, 3'b000, 8'h30, 8'h00, 3'b001, 3'b001, 0, 8'h00, 8'h5A);
        row(1, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3'b000, 0, 8'h00, 8'h00);
        row(0, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3'b000, 0, 8'h00, 8'h00);
        row(1, 3'b011, 3'b000, 8'h03, 8'h00, 3'b000, 3'b000, 0, 8'h00, 8'h00);
        row(1, 3'b011, 3'b000, 8'h03, 8'h00, 3'b001, 3'b000, 0, 8'h03, 8'h00);
        row(1, 3'b011, 3'b000, 8'h07, 8'h00, 3'b001, 3'b001, 0, 8'h07, 8'h03);
        row(1, 3'b011, 3'b011, 8'h03, 8'h07, 3'b001, 3'b001, 1, 8'h03, 8'h07);
        row(1, 3'b011, 3'b011, 8'h07, 8'h03, 3'b001, 3'b000, 1, 8'h07, 8'h00);
        row(1, 3'b010, 3'b000, 8'h03, 8'h00, 3'b001, 3'b000, 0, 8'h00, 8'h00);
        row(1, 3'b010, 3'b000, 8'h03, 8'h00, 3'b010, 3'b000, 0, 8'h03, 8'h00);
        row(1, 3'b010, 3'b000, 8'h07, 8'h00, 3'b010, 3'b010, 0, 8'h07, 8'h07);
        row(1, 3'b000, 3'b000, 8'h00, 8'h00, 3'b010, 3'b010, 0, 8'h00, 8'h03);
        row(1, 3'b000, 3'b000, 8'h00, 8'h00, 3'b000, 3'b000, 0, 8'h00, 8'h00);

        foreach (tv[i]) begin
            rst = tv[i].rst; req = tv[i].req; req_wren = tv[i].wren; lock = '0;
            req_addr = {N{tv[i].addr}}; req_wdata = {N{tv[i].wdata}};
            @(negedge clk);
            chk("tv_gnt", gnt, 32'(tv[i].eg));
            chk("tv_rd_valid", rd_valid, 32'(tv[i].ev));
            chk("tv_mem_wren", mem_wren, 32'(tv[i].ew));
            chk("tv_mem_address", mem_address, 32'(tv[i].ea));
            if (tv[i].ev != 0) chk("tv_rd_data", rd_data, 32'(tv[i].ed));
            fin();
        end

        // all three request together: tenures 0, 1, 2 with handover straight after each release cycle
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            req = {3'(i < 15), 3'(i < 10), 3'(i < 5)} == 0 ? '0 : {i < 15, i < 10, i < 5};
            req_wren = N'($urandom);
            rand_data();
            exp = (i == 0) ? 3'b000 : (i <= 5) ? 3'b001 : (i <= 10) ? 3'b010 : (i <= 15) ? 3'b100 : 3'b000;
            @(negedge clk);
            chk("simul_gnt", gnt, 32'(exp));
            fin();
        end

        // requesters 1 and 2 alternate with short tenures; pointer wraps past 2 back to 1
        do_reset();
        for (int i = 0; i <= 18; i++) begin
            req = {!(i % 6 == 0 && i > 0), i % 6 != 3, 1'b0};
            req_wren = '0;
            rand_data();
            exp = (i == 0) ? 3'b000 : (((i - 1) / 3) % 2 == 0) ? 3'b010 : 3'b100;
            @(negedge clk);
            chk("fair_gnt", gnt, 32'(exp));
            fin();
        end

`ifdef S_MEM_ARBITER_TIMEOUT_EN
        // unlocked holder is revoked after MH grant cycles; a locked holder keeps the RAM
        do_reset();
        for (int i = 0; i <= 12; i++) begin
            req = 3'b011; lock = 3'b000; req_wren = '0;
            rand_data();
            exp = (i == 0) ? 3'b000 : (i <= MH) ? 3'b001 : 3'b010;
            @(negedge clk);
            chk("timeout_gnt", gnt, 32'(exp));
            fin();
        end
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            req = 3'b011; lock = 3'b001; req_wren = '0;
            rand_data();
            exp = (i == 0) ? 3'b000 : 3'b001;
            @(negedge clk);
            chk("lock_gnt", gnt, 32'(exp));
            fin();
        end
`endif

        // random traffic with occasional resets against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r = req;
            for (int k = 0; k < N; k++) begin
                if (bit_at(r, k) ? $urandom_range(0, 5) == 0 : $urandom_range(0, 2) == 0)
                    r = r ^ (N'(1) << k);
            end
            req = r;
            rst = $urandom_range(0, 99) != 0;
            req_wren = N'($urandom) & N'($urandom);
            lock = N'($urandom);
            rand_data();
            @(negedge clk);
            fin();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
